// File: rtl/pic_pkg.sv
// Shared types, command codes and helpers for the 8259A-style interrupt controller core.
package pic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ACK1 = 2'd2,
        ACK2 = 2'd3
    } pic_state_t;

    localparam logic [1:0] EOI_NS       = 2'd0;
    localparam logic [1:0] EOI_SPEC     = 2'd1;
    localparam logic [1:0] EOI_ROT      = 2'd2;
    localparam logic [1:0] EOI_SETPRI   = 2'd3;
    localparam logic [2:0] SPURIOUS_LVL = 3'd7;

    // Distance from the highest-priority slot; 0 means most urgent.
    function automatic logic [2:0] prio_rank(input logic [2:0] lvl, input logic [2:0] sp);
        return lvl - sp - 3'd1;
    endfunction

    function automatic logic [7:0] lvl_onehot(input logic [2:0] lvl);
        return 8'h01 << lvl;
    endfunction

endpackage

// File: rtl/pic_prio_pick.sv
// Rotating-priority picker: first set bit of vec8 scanning sp+1, sp+2 .. sp (mod 8).
module pic_prio_pick (
    input  logic [7:0] vec8,
    input  logic [2:0] sp,
    output logic       any,
    output logic [2:0] lvl
);

    logic [2:0] idx;

    // Scan from lowest to highest priority so the most urgent hit is assigned last.
    always_comb begin
        any = 1'b0;
        lvl = 3'd0;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            idx = sp + 3'd1 + 3'(i);
            if (vec8[idx]) begin
                any = 1'b1;
                lvl = idx;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/pic_inta_ctrl.sv
// Interrupt sequencing core: IRR/ISR, rotating priority and the two-pulse INTA handshake.
// Optional automatic EOI at the second INTA is enabled by defining PIC_AEOI_EN.
module pic_inta_ctrl
    import pic_pkg::*;
#(
    parameter logic [7:0] VEC_BASE = 8'h08
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] request,
    input  logic [7:0] mask,
    input  logic       inta,
    input  logic       eoi_wr,
    input  logic [1:0] eoi_type,
    input  logic [2:0] eoi_lvl,
    output logic       intr,
    output logic [7:0] vec,
    output logic       vec_valid,
    output logic [7:0] irr,
    output logic [7:0] isr,
    output logic [2:0] sp
);

    pic_state_t state_q, state_d;
    logic [7:0] request_q;
    logic [7:0] irr_q, irr_d;
    logic [7:0] isr_q, isr_d;
    logic [2:0] sp_q, sp_d;
    logic [2:0] lvl_q, lvl_d;
    logic       intr_q, intr_d;
    logic [7:0] vec_q, vec_d;
    logic       vec_valid_q, vec_valid_d;
`ifdef PIC_AEOI_EN
    logic       lvl_real_q, lvl_real_d;
    logic       last_rot_q, last_rot_d;
`endif

    logic [7:0] elig_s;
    logic       e_any_s, t_any_s, win_valid_s;
    logic [2:0] w_lvl_s, t_lvl_s;
    logic [7:0] ack_set_s, eoi_clr_s, auto_clr_s;

    assign elig_s = irr_q & ~mask;

    pic_prio_pick u_pick_req (.vec8(elig_s), .sp(sp_q), .any(e_any_s), .lvl(w_lvl_s));
    pic_prio_pick u_pick_isr (.vec8(isr_q),  .sp(sp_q), .any(t_any_s), .lvl(t_lvl_s));

    // Equal rank never preempts: the winner must be strictly more urgent than the top in-service level.
    assign win_valid_s = e_any_s &&
                         (!t_any_s || (prio_rank(w_lvl_s, sp_q) < prio_rank(t_lvl_s, sp_q)));

    // Handshake FSM, EOI decode and next-state of all registers.
    always_comb begin
        state_d     = state_q;
        lvl_d       = lvl_q;
        vec_d       = vec_q;
        vec_valid_d = 1'b0;
        sp_d        = sp_q;
        ack_set_s   = 8'h00;
        eoi_clr_s   = 8'h00;
        auto_clr_s  = 8'h00;
`ifdef PIC_AEOI_EN
        lvl_real_d  = lvl_real_q;
        last_rot_d  = last_rot_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_valid_s) state_d = PEND;
                else             state_d = IDLE;
            end
            PEND: begin
                if (inta) begin
                    state_d = ACK1;
                    if (win_valid_s) begin
                        lvl_d     = w_lvl_s;
                        ack_set_s = lvl_onehot(w_lvl_s);
                    end else begin
                        lvl_d     = SPURIOUS_LVL;
                    end
`ifdef PIC_AEOI_EN
                    lvl_real_d = win_valid_s;
`endif
                end else begin
                    state_d = PEND;
                end
            end
            ACK1: begin
                if (inta) begin
                    state_d     = ACK2;
                    vec_d       = {VEC_BASE[7:3], lvl_q};
                    vec_valid_d = 1'b1;
`ifdef PIC_AEOI_EN
                    if (lvl_real_q) begin
                        auto_clr_s = lvl_onehot(lvl_q);
                        if (last_rot_q) sp_d = lvl_q;
                        else            sp_d = sp_q;
                    end else begin
                        auto_clr_s = 8'h00;
                    end
`endif
                end else begin
                    state_d = ACK1;
                end
            end
            ACK2: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Commands act on the pre-ack isr and override any automatic rotation.
        if (eoi_wr) begin
`ifdef PIC_AEOI_EN
            last_rot_d = (eoi_type == EOI_ROT);
`endif
            case (eoi_type)
                EOI_NS:     eoi_clr_s = t_any_s ? lvl_onehot(t_lvl_s) : 8'h00;
                EOI_SPEC:   eoi_clr_s = lvl_onehot(eoi_lvl);
                EOI_ROT: begin
                    if (t_any_s) begin
                        eoi_clr_s = lvl_onehot(t_lvl_s);
                        sp_d      = t_lvl_s;
                    end else begin
                        eoi_clr_s = 8'h00;
                    end
                end
                EOI_SETPRI: sp_d = eoi_lvl;
                default:    eoi_clr_s = 8'h00;
            endcase
        end else begin
            eoi_clr_s = 8'h00;
        end

        irr_d  = (irr_q & ~ack_set_s) | (request & ~request_q);
        isr_d  = (isr_q & ~eoi_clr_s & ~auto_clr_s) | ack_set_s;
        intr_d = (state_d == PEND) || (state_d == ACK1);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            request_q   <= 8'h00;
            irr_q       <= 8'h00;
            isr_q       <= 8'h00;
            sp_q        <= 3'd7;
            lvl_q       <= 3'd0;
            intr_q      <= 1'b0;
            vec_q       <= 8'h00;
            vec_valid_q <= 1'b0;
`ifdef PIC_AEOI_EN
            lvl_real_q  <= 1'b0;
            last_rot_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            request_q   <= request;
            irr_q       <= irr_d;
            isr_q       <= isr_d;
            sp_q        <= sp_d;
            lvl_q       <= lvl_d;
            intr_q      <= intr_d;
            vec_q       <= vec_d;
            vec_valid_q <= vec_valid_d;
`ifdef PIC_AEOI_EN
            lvl_real_q  <= lvl_real_d;
            last_rot_q  <= last_rot_d;
`endif
        end
    end

    assign intr      = intr_q;
    assign vec       = vec_q;
    assign vec_valid = vec_valid_q;
    assign irr       = irr_q;
    assign isr       = isr_q;
    assign sp        = sp_q;

endmodule

// File: tb/tb_pic_inta_ctrl.sv
// Directed bench for pic_inta_ctrl with a rank-based reference model checked every cycle.
module tb_pic_inta_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] request = 8'h00;
    logic [7:0] mask = 8'h00;
    logic       inta = 1'b0;
    logic       eoi_wr = 1'b0;
    logic [1:0] eoi_type = 2'd0;
    logic [2:0] eoi_lvl = 3'd0;
    logic       intr, vec_valid;
    logic [7:0] vec, irr, isr;
    logic [2:0] sp;

    int n_pass = 0;
    int n_total = 0;

    pic_inta_ctrl dut (
        .clk(clk), .reset(reset), .request(request), .mask(mask), .inta(inta),
        .eoi_wr(eoi_wr), .eoi_type(eoi_type), .eoi_lvl(eoi_lvl),
        .intr(intr), .vec(vec), .vec_valid(vec_valid), .irr(irr), .isr(isr), .sp(sp)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit [7:0] m_irr, m_isr, m_prev, m_vec;
    int       m_sp, m_phase, m_lvl;
    bit       m_real, m_lastrot, m_intr, m_vv;

    function automatic int rank(int x, int s);
        return (x - s - 1 + 16) % 8;
    endfunction

    // Most urgent set bit by minimum rank; -1 when empty.
    function automatic int best(bit [7:0] v, int s);
        int b = -1;
        for (int i = 0; i < 8; i++)
            if (v[i] && (b < 0 || rank(i, s) < rank(b, s))) b = i;
        return b;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_irr = 0; m_isr = 0; m_prev = 0; m_vec = 0; m_sp = 7; m_phase = 0;
            m_lvl = 0; m_real = 0; m_lastrot = 0; m_intr = 0; m_vv = 0;
        end else begin
            bit [7:0] e, setb, clrb;
            int w, t, nsp;
            bit v;
            e = m_irr & ~mask;
            w = best(e, m_sp);
            t = best(m_isr, m_sp);
            v = (w >= 0) && (t < 0 || rank(w, m_sp) < rank(t, m_sp));
            setb = 0; clrb = 0; nsp = m_sp; m_vv = 0;
            if (m_phase == 0) begin
                if (v) m_phase = 1;
            end else if (m_phase == 1) begin
                if (inta) begin
                    m_phase = 2;
                    m_real = v;
                    m_lvl = v ? w : 7;
                    if (v) setb[w] = 1'b1;
                end
            end else if (m_phase == 2) begin
                if (inta) begin
                    m_phase = 3;
                    m_vv = 1;
                    m_vec = 8'h08 + 8'(m_lvl);
`ifdef PIC_AEOI_EN
                    if (m_real) begin
                        clrb[m_lvl] = 1'b1;
                        if (m_lastrot) nsp = m_lvl;
                    end
`endif
                end
            end else begin
                m_phase = 0;
            end
            if (eoi_wr) begin
                m_lastrot = (eoi_type == 2'd2);
                if (eoi_type == 2'd0 && t >= 0) clrb[t] = 1'b1;
                if (eoi_type == 2'd1) clrb[eoi_lvl] = 1'b1;
                if (eoi_type == 2'd2 && t >= 0) begin clrb[t] = 1'b1; nsp = t; end
                if (eoi_type == 2'd3) nsp = eoi_lvl;
            end
            m_irr = (m_irr & ~setb) | (request & ~m_prev);
            m_isr = (m_isr & ~clrb) | setb;
            m_prev = request;
            m_sp = nsp;
            m_intr = (m_phase == 1 || m_phase == 2);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("model_intr", 32'(intr), 32'(m_intr));
        chk("model_irr", 32'(irr), 32'(m_irr));
        chk("model_isr", 32'(isr), 32'(m_isr));
        chk("model_sp", 32'(sp), 32'(m_sp));
        chk("model_vec_valid", 32'(vec_valid), 32'(m_vv));
        if (m_vv) chk("model_vec", 32'(vec), 32'(m_vec));
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic inta1();
        inta = 1'b1; step(); inta = 1'b0;
    endtask

    task automatic eoi(input logic [1:0] ty, input logic [2:0] lv);
        eoi_wr = 1'b1; eoi_type = ty; eoi_lvl = lv; step(); eoi_wr = 1'b0;
    endtask

    task automatic edge_req(input logic [7:0] r);
        request = r; step(); request = 8'h00;
    endtask

    initial begin
        step(); step();
        chk("rst_isr", 32'(isr), 32'h0);
        chk("rst_sp", 32'(sp), 32'd7);
        chk("rst_intr", 32'(intr), 32'd0);
        reset = 1'b0;
        step();

        // 1: basic ack of IR2
        edge_req(8'h04);
        chk("t1_irr", 32'(irr), 32'h04);
        chk("t1_intr_early", 32'(intr), 32'd0);
        step();
        chk("t1_intr", 32'(intr), 32'd1);
        inta1();
        chk("t1_isr", 32'(isr), 32'h04);
        chk("t1_irr_clr", 32'(irr), 32'h00);
        inta1();
        chk("t1_vv", 32'(vec_valid), 32'd1);
        chk("t1_vec", 32'(vec), 32'h0A);
        chk("t1_intr_drop", 32'(intr), 32'd0);
        step();
        chk("t1_vv_pulse", 32'(vec_valid), 32'd0);

        // 2: preempt by IR1, then IR5 blocked until EOI
        edge_req(8'h02);
        step();
        chk("t2_preempt", 32'(intr), 32'd1);
        inta1(); inta1();
        chk("t2_vec", 32'(vec), 32'h09);
        chk("t2_isr", 32'(isr), 32'h06);
        eoi(2'd0, 3'd0);
        chk("t2_ns_eoi", 32'(isr), 32'h04);
        edge_req(8'h20);
        step(); step();
        chk("t2_blocked", 32'(intr), 32'd0);
        eoi(2'd0, 3'd0);
        step();
        chk("t2_unblocked", 32'(intr), 32'd1);
        inta1(); inta1();
        chk("t2_vec5", 32'(vec), 32'h0D);
        eoi(2'd1, 3'd5);
        chk("t2_spec_eoi", 32'(isr), 32'h00);

        // 3: spurious ack after masking
        edge_req(8'h08);
        step();
        chk("t3_intr", 32'(intr), 32'd1);
        mask = 8'h08;
        step();
        inta1();
        chk("t3_isr", 32'(isr), 32'h00);
        chk("t3_irr", 32'(irr), 32'h08);
        inta1();
        chk("t3_vec", 32'(vec), 32'h0F);
        mask = 8'h00;
        step(); step();
        inta1(); inta1();
        chk("t3_vec3", 32'(vec), 32'h0B);
        eoi(2'd1, 3'd3);

        // 4: rotate on EOI, then simultaneous IR0/IR2
        edge_req(8'h02);
        step();
        inta1(); inta1();
        chk("t4_isr", 32'(isr), 32'h02);
        eoi(2'd2, 3'd0);
        chk("t4_rot_isr", 32'(isr), 32'h00);
        chk("t4_rot_sp", 32'(sp), 32'd1);
        edge_req(8'h05);
        step();
        inta1(); inta1();
        chk("t4_vec", 32'(vec), 32'h0A);
        eoi(2'd0, 3'd0);
        step();
        inta1(); inta1();
        chk("t4_vec0", 32'(vec), 32'h08);
        eoi(2'd0, 3'd0);
        eoi(2'd3, 3'd7);
        chk("t4_setpri", 32'(sp), 32'd7);

        // 5: reset between the two INTA pulses
        edge_req(8'h10);
        step();
        inta1();
        reset = 1'b1;
        step();
        chk("t5_isr", 32'(isr), 32'h00);
        chk("t5_irr", 32'(irr), 32'h00);
        chk("t5_intr", 32'(intr), 32'd0);
        reset = 1'b0;
        inta1();
        chk("t5_no_vv", 32'(vec_valid), 32'd0);

        // 6: IR6, automatic vs explicit EOI
        edge_req(8'h40);
        step();
        inta1();
        chk("t6_isr_set", 32'(isr), 32'h40);
        inta1();
        chk("t6_vec", 32'(vec), 32'h0E);
`ifdef PIC_AEOI_EN
        chk("t6_aeoi", 32'(isr), 32'h00);
`else
        chk("t6_held", 32'(isr), 32'h40);
        step();
        chk("t6_held2", 32'(isr), 32'h40);
`endif
        eoi(2'd1, 3'd6);
        chk("t6_cleared", 32'(isr), 32'h00);
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
